// File: rtl/csr_perf_counters_if.sv
// CSR-side bundle feeding the performance counter unit: read/write ports
// plus the EXE/commit event signals it counts.
interface csr_perf_counters_if #(
    parameter int COMMIT_WIDTH = 2
);
    localparam int RW = $clog2(COMMIT_WIDTH + 1);

    logic [11:0]   csr_raddr_i;
    logic [31:0]   rdata_o;
    logic          hit_o;
    logic          csr_we_i;
    logic [11:0]   csr_waddr_i;
    logic [31:0]   csr_wdata_i;
    logic [RW-1:0] retire_cnt_i;
    logic          exe_stall;
    logic          exe_is_branch;
    logic          exe_misspredict;
    logic          recovery_procedure;

    modport master (
        output csr_raddr_i, csr_we_i, csr_waddr_i, csr_wdata_i, retire_cnt_i,
               exe_stall, exe_is_branch, exe_misspredict, recovery_procedure,
        input  rdata_o, hit_o
    );

    modport slave (
        input  csr_raddr_i, csr_we_i, csr_waddr_i, csr_wdata_i, retire_cnt_i,
               exe_stall, exe_is_branch, exe_misspredict, recovery_procedure,
        output rdata_o, hit_o
    );
endinterface

// File: rtl/csr_perf_counters.sv
// Machine-mode performance counters (mcycle, minstret, hpm3..5) with
// mcountinhibit gating, combinational reads and commit-stage writes.
module csr_perf_counters #(
    parameter int COMMIT_WIDTH = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    csr_perf_counters_if.slave   bus
);
    localparam int RW = $clog2(COMMIT_WIDTH + 1);
    localparam logic [31:0] INHIBIT_MASK = 32'h0000_003D;

    // Slot k holds counter C0, C2, C3, C4, C5 for k = 0..4.
    logic [63:0] cnt   [5];
    logic [63:0] inc   [5];
    logic [31:0] mcountinhibit;
    logic [4:0]  inhibit;
    logic [RW-1:0] retire;

    logic        r_hit, r_cnt;
    logic [2:0]  r_slot;
    logic        w_cnt, w_inh, w_hi;
    logic [2:0]  w_slot;

    function automatic logic is_counter(input logic [11:0] a, input logic [3:0] page);
        return (a[11:8] == page) && (a[6:3] == 4'd0) && (a[2:0] != 3'd1) && (a[2:0] <= 3'd5);
    endfunction

    function automatic logic [2:0] slot_of(input logic [2:0] n);
        return (n == 3'd0) ? 3'd0 : n - 3'd1;
    endfunction

    assign retire  = bus.retire_cnt_i;
    assign inhibit = {mcountinhibit[5:2], mcountinhibit[0]};

    always_comb begin
        inc[0] = 64'd1;
        inc[1] = 64'(retire);
        inc[2] = 64'(bus.exe_is_branch && !bus.exe_stall);
        inc[3] = 64'(bus.exe_is_branch && bus.exe_misspredict && !bus.exe_stall);
        inc[4] = 64'(bus.exe_stall || bus.recovery_procedure);
    end

    always_comb begin
        r_cnt  = is_counter(bus.csr_raddr_i, 4'hB) || is_counter(bus.csr_raddr_i, 4'hC);
        r_slot = slot_of(bus.csr_raddr_i[2:0]);
        r_hit  = r_cnt || (bus.csr_raddr_i == 12'h320);
        bus.hit_o   = r_hit;
        bus.rdata_o = 32'd0;
        if (r_cnt)
            bus.rdata_o = bus.csr_raddr_i[7] ? cnt[r_slot][63:32] : cnt[r_slot][31:0];
        else if (r_hit)
            bus.rdata_o = mcountinhibit;
    end

    // Shadow (0xCxx) addresses are read-only, so only the 0xBxx page decodes here.
    always_comb begin
        w_cnt  = bus.csr_we_i && is_counter(bus.csr_waddr_i, 4'hB);
        w_inh  = bus.csr_we_i && (bus.csr_waddr_i == 12'h320);
        w_hi   = bus.csr_waddr_i[7];
        w_slot = slot_of(bus.csr_waddr_i[2:0]);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mcountinhibit <= 32'd0;
            for (int k = 0; k < 5; k++) cnt[k] <= 64'd0;
        end else begin
            if (w_inh) mcountinhibit <= bus.csr_wdata_i & INHIBIT_MASK;
            for (int k = 0; k < 5; k++) begin
                if (w_cnt && (w_slot == 3'(k))) begin
                    if (w_hi) cnt[k][63:32] <= bus.csr_wdata_i;
                    else      cnt[k][31:0]  <= bus.csr_wdata_i;
                end else if (!inhibit[k]) begin
                    cnt[k] <= cnt[k] + inc[k];
                end
            end
        end
    end
endmodule

// File: tb/tb_csr_perf_counters.sv
// Directed bench for csr_perf_counters with hand-computed expected values.
module tb_csr_perf_counters;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    csr_perf_counters_if #(.COMMIT_WIDTH(2)) bus ();

    csr_perf_counters #(.COMMIT_WIDTH(2)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance n edges; inputs change 1 time unit after the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
        bus.csr_raddr_i = a;
        #1;
        chk(tag, bus.rdata_o, exp);
    endtask

    task automatic rdhit(input string tag, input logic [11:0] a, input logic exp);
        bus.csr_raddr_i = a;
        #1;
        chk(tag, 32'(bus.hit_o), 32'(exp));
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        bus.csr_we_i    = 1'b1;
        bus.csr_waddr_i = a;
        bus.csr_wdata_i = d;
        step(1);
        bus.csr_we_i    = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.csr_raddr_i = 12'h0;
        bus.csr_we_i = 1'b0;
        bus.csr_waddr_i = 12'h0;
        bus.csr_wdata_i = 32'h0;
        bus.retire_cnt_i = 2'd0;
        bus.exe_stall = 1'b0;
        bus.exe_is_branch = 1'b0;
        bus.exe_misspredict = 1'b0;
        bus.recovery_procedure = 1'b0;
        step(2);
        rst = 1'b0;
        rd("reset_mcycle", 12'hB00, 32'd0);
        rd("reset_inhibit", 12'h320, 32'd0);

        step(10);
        rd("idle_mcycle_lo", 12'hB00, 32'd10);
        rd("idle_mcycle_hi", 12'hB80, 32'd0);
        rd("shadow_cycle", 12'hC00, 32'd10);
        rdhit("shadow_hit", 12'hC00, 1'b1);
        rdhit("bad_addr_hit", 12'h123, 1'b0);
        rd("bad_addr_data", 12'h123, 32'd0);
        rdhit("c1_unmapped", 12'hB01, 1'b0);

        bus.retire_cnt_i = 2'd2; step(1);
        bus.retire_cnt_i = 2'd1; step(1);
        bus.retire_cnt_i = 2'd0; step(1);
        bus.retire_cnt_i = 2'd2; step(1);
        bus.retire_cnt_i = 2'd0;
        rd("instret_5", 12'hB02, 32'd5);
        wr(12'h320, 32'h4);
        bus.retire_cnt_i = 2'd2; step(3);
        bus.retire_cnt_i = 2'd0;
        rd("instret_inhibited", 12'hB02, 32'd5);
        rd("cycle_runs", 12'hB00, 32'd18);
        wr(12'h320, 32'hFFFF_FFFF);
        rd("inhibit_mask", 12'h320, 32'h3D);
        wr(12'h320, 32'h0);
        rd("cycle_frozen", 12'hB00, 32'd19);

        bus.exe_is_branch = 1'b1; bus.exe_stall = 1'b1; step(3);
        bus.exe_stall = 1'b0; step(1);
        rd("branch_after_stall", 12'hB03, 32'd1);
        bus.exe_misspredict = 1'b1; step(1);
        bus.exe_is_branch = 1'b0; bus.exe_misspredict = 1'b0;
        rd("branch_2", 12'hB03, 32'd2);
        rd("mispredict_1", 12'hB04, 32'd1);
        rd("stall_3", 12'hB05, 32'd3);
        wr(12'hB05, 32'd0);
        bus.exe_stall = 1'b1; step(3);
        bus.recovery_procedure = 1'b1; step(1);
        bus.exe_stall = 1'b0; step(1);
        bus.recovery_procedure = 1'b0;
        rd("stall_5", 12'hB05, 32'd5);
        rd("shadow_branch", 12'hC03, 32'd2);

        wr(12'hB80, 32'hFFFF_FFFF);
        wr(12'hB00, 32'hFFFF_FFFE);
        step(3);
        rd("wrap_lo", 12'hB00, 32'd1);
        rd("wrap_hi", 12'hB80, 32'd0);
        wr(12'hB80, 32'h0);
        wr(12'hB00, 32'hFFFF_FFFF);
        rd("pre_carry_lo", 12'hB00, 32'hFFFF_FFFF);
        step(1);
        rd("carry_lo", 12'hB00, 32'd0);
        rd("carry_hi", 12'hB80, 32'd1);

        wr(12'hB82, 32'h7);
        rd("hi_write_keeps_lo", 12'hB02, 32'd5);
        bus.retire_cnt_i = 2'd2;
        wr(12'hB02, 32'h100);
        bus.retire_cnt_i = 2'd0;
        rd("write_beats_inc", 12'hB02, 32'h100);
        rd("write_keeps_hi", 12'hB82, 32'h7);

        wr(12'hC00, 32'h0);
        rd("c00_write_ignored", 12'hB00, 32'd3);
        rd("shadow_hi", 12'hC80, 32'd1);

        wr(12'h320, 32'h20);
        rst = 1'b1;
        bus.retire_cnt_i = 2'd2;
        wr(12'hB02, 32'h55);
        rst = 1'b0;
        bus.retire_cnt_i = 2'd0;
        rd("rst_cycle", 12'hB00, 32'd0);
        rd("rst_cycle_hi", 12'hB80, 32'd0);
        rd("rst_instret", 12'hB02, 32'd0);
        rd("rst_instret_hi", 12'hB82, 32'd0);
        rd("rst_inhibit", 12'h320, 32'd0);
        rd("rst_branch", 12'hB03, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/csr_perf_counters.md
# csr_perf_counters

Machine-mode hardware performance counter unit placed beside the CSR file and fed by the same EXE/commit signals carried on the CSR interface. It keeps 64-bit cycle, retired-instruction, branch, mispredict and stall-cycle counters, gated by `mcountinhibit`. It serves combinational CSR reads for the decode/EXE read path and accepts commit-stage CSR writes. The CSR module muxes `hit_o`/`rdata_o` into its `csr_data_o`.

## Interface
- `COMMIT_WIDTH`, 2: maximum instructions retired per cycle.
- `clk_i`  in  1  core clock.
- `rst_i`  in  1  reset; synchronous, active-high.
- `csr_raddr_i`  in  12  CSR read address (same as CSR read port).
- `rdata_o`  out  32  read data; 0 when `hit_o`=0.
- `hit_o`  out  1  `csr_raddr_i` decodes to a counter or `mcountinhibit`.
- `csr_we_i`  in  1  commit-stage CSR write strobe.
- `csr_waddr_i`  in  12  write address.
- `csr_wdata_i`  in  32  write data.
- `retire_cnt_i`  in  $clog2(COMMIT_WIDTH+1)  instructions retired this cycle (0..COMMIT_WIDTH).
- `exe_stall`  in  1  EXE stage stalled this cycle.
- `exe_is_branch`  in  1  EXE holds a branch/jump.
- `exe_misspredict`  in  1  that branch was mispredicted.
- `recovery_procedure`  in  1  ROB recovery in progress.

## Operation
- Counters, all 64-bit, wrap modulo 2^64:
  - C0 `mcycle`: +1 every cycle.
  - C2 `minstret`: +`retire_cnt_i`.
  - C3: +1 when `exe_is_branch && !exe_stall`.
  - C4: +1 when `exe_is_branch && exe_misspredict && !exe_stall`.
  - C5: +1 when `exe_stall || recovery_procedure`.
- `mcountinhibit` (0x320): 32-bit register. Implemented bits are 0, 2, 3, 4 and 5; all other bits read 0 and ignore writes. Bit n=1 freezes Cn. Inhibit is sampled in the same cycle as the increment condition.
- Read map, combinational:
  - Low words: 0xB00, 0xB02, 0xB03–0xB05.
  - High words: 0xB80, 0xB82, 0xB83–0xB85.
  - User read-only shadows: 0xC00/0xC02/0xC03–0xC05 and 0xC80/0xC82/0xC83–0xC85 return the same values.
  - 0x320 returns `mcountinhibit`. Any other address gives `hit_o`=0, `rdata_o`=0.
- Writes: only machine addresses (0xBxx, 0x320) are writable. A write to 0xCxx is ignored; illegality is trapped elsewhere.
  - Writing a low word loads bits 31:0 and keeps bits 63:32.
  - Writing a high word loads bits 63:32 and keeps bits 31:0.
- Write vs increment in the same cycle: the write wins. The whole 64-bit counter takes the written half plus the unchanged other half, with no increment that cycle.
- The increment carries across the 32-bit boundary in the same cycle: 0x0000_0000_FFFF_FFFF + 1 = 0x0000_0001_0000_0000.
- Reads reflect register state before this cycle's update; there is no read-after-write bypass.

## Timing
- Reset: all counters = 0 and `mcountinhibit` = 0, taking effect at the first rising edge with `rst_i`=1. Reset mid-count takes priority over writes and increments.
- Outputs while in reset: `rdata_o` follows the reset register state, so it reads 0 from the cycle after the reset edge.
- Read latency: 0 cycles (combinational from `csr_raddr_i`).
- Write and increment latency: visible on reads in the cycle after the edge.
- No handshake. Every input is sampled on every edge and `csr_we_i` is a single-cycle pulse.
- Critical path: 64-bit increment plus the write mux. C2 adds at most COMMIT_WIDTH per cycle.

## Test plan
- Reset, then 10 idle cycles:
  - read 0xB00 → 10 and 0xB80 → 0.
  - read 0xC00 → 10 with `hit_o`=1.
  - read 0x123 → `hit_o`=0, `rdata_o`=0.
- Retire 2,1,0,2 over 4 cycles: 0xB02 reads 5. Then write 0x320 = 0x4, retire 2 for 3 cycles: 0xB02 stays 5 and 0xB00 keeps counting. Write 0x320 = 0xFFFF_FFFF: readback 0x3D.
- Branch stream:
  - branch with `exe_stall`=1 for 3 cycles, then released: C3 = 1.
  - a mispredicted branch not stalled: C3 = 2, C4 = 1.
  - stall 4 cycles plus recovery 2 overlapping cycles (5 distinct cycles): C5 = 5.
- Wrap: write 0xB80 = 0xFFFF_FFFF and 0xB00 = 0xFFFF_FFFE, wait 3 cycles:
  - 0xB00 reads 1 and 0xB80 reads 0.
  - the carry from 0x0000_0000_FFFF_FFFF appears in the high word after one increment.
- Same-cycle write and increment: write 0xB02 = 0x100 while `retire_cnt_i`=2 → next cycle 0xB02 = 0x100 and the high word is unchanged.
- A write to 0xC00 is ignored, and reset asserted mid-run clears all counters the next cycle.
